// File: rtl/mode_seq_pkg.sv
// mode_seq_pkg: channel/LED config encodings and the default mode tables
// shared by the mode sequencer and its users.
package mode_seq_pkg;

    typedef enum logic [1:0] {
        CH_LOW   = 2'b00,
        CH_HIGH  = 2'b01,
        CH_TIMED = 2'b10,
        CH_INV   = 2'b11
    } ch_cfg_e;

    typedef enum logic [1:0] {
        LED_OFF  = 2'b00,
        LED_ON   = 2'b01,
        LED_SLOW = 2'b10,
        LED_FAST = 2'b11
    } led_cfg_e;

    localparam int MAX_MODES = 16;
    localparam int MAX_CH    = 16;

    // 4 modes x 4 channels, mode-major, channel 0 in the low bits of each mode
    localparam logic [31:0] CH_CFG_DEF  = 32'h0140_AA44;
    localparam logic [7:0]  LED_CFG_DEF = 8'h36;

    function automatic logic [2*MAX_MODES*MAX_CH-1:0] ch_cfg_default(
        input int modes,
        input int chans
    );
        logic [2*MAX_MODES*MAX_CH-1:0] cfg;
        cfg = '0;
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 4; c++) begin
                if (m < modes && c < chans) begin
                    cfg[2*(m*chans+c) +: 2] = CH_CFG_DEF[2*(m*4+c) +: 2];
                end
            end
        end
        return cfg;
    endfunction

    function automatic logic [2*MAX_MODES-1:0] led_cfg_default(
        input int modes
    );
        logic [2*MAX_MODES-1:0] cfg;
        cfg = '0;
        for (int m = 0; m < 4; m++) begin
            if (m < modes) begin
                cfg[2*m +: 2] = LED_CFG_DEF[2*m +: 2];
            end
        end
        return cfg;
    endfunction

endpackage

// File: rtl/mode_sequencer_debounce.sv
// button_debounce: polls an active-low button on sample_tick and emits
// a one-cycle press pulse for every debounced released->pressed change.
module button_debounce #(
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic raw_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);

    logic          smp;
    logic          acc_q, acc_d;
    logic          arm_q, arm_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign smp = ~raw_n;

    always_comb begin
        acc_d   = acc_q;
        arm_d   = arm_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sample_tick) begin
            if (smp == acc_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEBOUNCE_SAMPLES - 1)) begin
                acc_d   = smp;
                cnt_d   = '0;
                press_d = smp & arm_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // a button held through reset must be seen released before it counts
            if (!smp && !acc_d) begin
                arm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= 1'b0;
            arm_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: button-stepped mode register with guarded channel outputs
// and a mode LED. Define MODE_DIRECT_SELECT_EN to add mode_load/mode_sel.
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int NUM_MODES        = 4,
    parameter int NUM_CH           = 4,
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int GUARD_CYCLES     = 2,
    parameter logic [2*NUM_MODES*NUM_CH-1:0] CH_CFG =
        (2*NUM_MODES*NUM_CH)'(ch_cfg_default(NUM_MODES, NUM_CH)),
    parameter logic [2*NUM_MODES-1:0] LED_CFG =
        (2*NUM_MODES)'(led_cfg_default(NUM_MODES)),
    localparam int MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_tick,
    input  logic              mode_button_n,
    input  logic              slow_pulse,
    input  logic              fast_pulse,
    input  logic [NUM_CH-1:0] timed_ch,
`ifdef MODE_DIRECT_SELECT_EN
    input  logic              mode_load,
    input  logic [MODE_W-1:0] mode_sel,
`endif
    output logic [MODE_W-1:0] mode,
    output logic              mode_changed,
    output logic              initial_state,
    output logic              led,
    output logic [NUM_CH-1:0] ch_out
);

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    logic              press;
    logic              chg;
    logic [MODE_W-1:0] nxt_mode;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              init_q, init_d;
    logic              upd_q;
    logic              mchg_q;
    logic [GW-1:0]     guard_q, guard_d;
    logic [NUM_CH-1:0] ch_val, ch_q, ch_d;
    logic              led_val, led_q;

    button_debounce #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_tick(sample_tick),
        .raw_n      (mode_button_n),
        .press      (press)
    );

    always_comb begin
        chg      = press;
        nxt_mode = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
`ifdef MODE_DIRECT_SELECT_EN
        // a valid load wins over a simultaneous press
        if (mode_load && (int'(mode_sel) < NUM_MODES)) begin
            chg      = 1'b1;
            nxt_mode = mode_sel;
        end
`endif
    end

    always_comb begin
        ch_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            unique case (ch_cfg_e'(CH_CFG[2*(int'(mode_q)*NUM_CH+c) +: 2]))
                CH_LOW:   ch_val[c] = 1'b0;
                CH_HIGH:  ch_val[c] = 1'b1;
                CH_TIMED: ch_val[c] = timed_ch[c];
                CH_INV:   ch_val[c] = ~timed_ch[c];
            endcase
        end
    end

    always_comb begin
        led_val = 1'b0;
        unique case (led_cfg_e'(LED_CFG[2*int'(mode_q) +: 2]))
            LED_OFF:  led_val = 1'b0;
            LED_ON:   led_val = 1'b1;
            LED_SLOW: led_val = slow_pulse;
            LED_FAST: led_val = fast_pulse;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        init_d  = init_q;
        guard_d = guard_q;
        ch_d    = ch_val;
        if (chg) begin
            mode_d = nxt_mode;
            init_d = 1'b0;
        end
        if (chg && GUARD_CYCLES > 0) begin
            guard_d = GW'(GUARD_CYCLES - 1);
            ch_d    = '0;
        end else if (guard_q != '0) begin
            guard_d = guard_q - 1'b1;
            ch_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= '0;
            init_q  <= 1'b1;
            upd_q   <= 1'b0;
            mchg_q  <= 1'b0;
            guard_q <= '0;
            ch_q    <= '0;
            led_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            init_q  <= init_d;
            upd_q   <= chg;
            mchg_q  <= upd_q;
            guard_q <= guard_d;
            ch_q    <= ch_d;
            led_q   <= led_val;
        end
    end

    assign mode          = mode_q;
    assign mode_changed  = mchg_q;
    assign initial_state = init_q;
    assign led           = led_q;
    assign ch_out        = ch_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: vector table, corner sequences and a randomized run
// against a rule-level model of the mode sequencer.
`timescale 1ns/1ps
module tb_mode_sequencer;

    localparam int NM = 4;
    localparam int DS = 3;
    localparam int G  = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       btn0  = 1'b1;
    logic       btn1  = 1'b1;
    logic       slow  = 1'b0;
    logic       fast  = 1'b0;
    logic [3:0] timed = '0;

    logic [1:0] mode0, mode1;
    logic       chg0, chg1, init0, init1, led0, led1;
    logic [3:0] ch0, ch1;
`ifdef MODE_DIRECT_SELECT_EN
    logic       ld0  = 1'b0;
    logic [1:0] sel0 = '0;
    logic       ld2  = 1'b0;
    logic [2:0] sel2 = '0;
    logic [2:0] mode2;
    logic       chg2, init2, led2;
    logic [3:0] ch2;
`endif

    int checks = 0;
    int errors = 0;

    // spec tables: channel code 0 low, 1 high, 2 timed, 3 inverted timed
    int ch_tbl [4][4] = '{'{0,1,0,1}, '{2,2,2,2}, '{0,0,0,1}, '{1,0,0,0}};
    // led code 0 off, 1 on, 2 slow, 3 fast
    int led_tbl [4] = '{2, 1, 3, 0};

    int         m_mode;
    bit         m_init;
    int         m_age;
    bit         m_prev_chg;
    bit         m_press;
    bit         m_acc;
    int         m_run;
    bit         m_armed;
    logic [3:0] e_ch;
    bit         e_led;
    bit         e_chg;

    typedef struct {
        int         n;
        bit         s;
        bit         f;
        logic [3:0] t;
        int         m;
        bit         l;
        logic [3:0] c;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    mode_sequencer dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (tick),
        .mode_button_n(btn0),
        .slow_pulse   (slow),
        .fast_pulse   (fast),
        .timed_ch     (timed),
`ifdef MODE_DIRECT_SELECT_EN
        .mode_load    (ld0),
        .mode_sel     (sel0),
`endif
        .mode         (mode0),
        .mode_changed (chg0),
        .initial_state(init0),
        .led          (led0),
        .ch_out       (ch0)
    );

    mode_sequencer #(
        .DEBOUNCE_SAMPLES(1),
        .GUARD_CYCLES    (4)
    ) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (tick),
        .mode_button_n(btn1),
        .slow_pulse   (slow),
        .fast_pulse   (fast),
        .timed_ch     (timed),
`ifdef MODE_DIRECT_SELECT_EN
        .mode_load    (1'b0),
        .mode_sel     (2'b00),
`endif
        .mode         (mode1),
        .mode_changed (chg1),
        .initial_state(init1),
        .led          (led1),
        .ch_out       (ch1)
    );

`ifdef MODE_DIRECT_SELECT_EN
    mode_sequencer #(
        .NUM_MODES(5)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (tick),
        .mode_button_n(1'b1),
        .slow_pulse   (slow),
        .fast_pulse   (fast),
        .timed_ch     (timed),
        .mode_load    (ld2),
        .mode_sel     (sel2),
        .mode         (mode2),
        .mode_changed (chg2),
        .initial_state(init2),
        .led          (led2),
        .ch_out       (ch2)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit chan(input int code, input bit t);
        case (code)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return t;
            default: return !t;
        endcase
    endfunction

    function automatic bit ledv(input int code, input bit s, input bit f);
        case (code)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return s;
            default: return f;
        endcase
    endfunction

    // advance the model by one clock edge using the inputs now applied
    task automatic model_step();
        bit chg;
        bit s;
        bit nxt_press;
        int tgt;
        if (!rst_n) begin
            m_mode = 0; m_init = 1; m_age = 1000; m_prev_chg = 0;
            m_press = 0; m_acc = 0; m_run = 0; m_armed = 0;
            e_ch = '0; e_led = 0; e_chg = 0;
            return;
        end
        chg = m_press;
        tgt = (m_mode + 1) % NM;
`ifdef MODE_DIRECT_SELECT_EN
        if (ld0 && int'(sel0) < NM) begin
            chg = 1;
            tgt = int'(sel0);
        end
`endif
        m_age = chg ? 0 : ((m_age < 1000) ? m_age + 1 : 1000);
        for (int c = 0; c < 4; c++) begin
            e_ch[c] = (m_age < G) ? 1'b0 : chan(ch_tbl[m_mode][c], timed[c]);
        end
        e_led = ledv(led_tbl[m_mode], slow, fast);
        e_chg = m_prev_chg;
        m_prev_chg = chg;
        if (chg) begin
            m_mode = tgt;
            m_init = 0;
        end
        nxt_press = 0;
        if (tick) begin
            s = !btn0;
            if (s == m_acc) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DS) begin
                    m_acc = s;
                    m_run = 0;
                    nxt_press = s && m_armed;
                end
            end
            if (!s && !m_acc) m_armed = 1;
        end
        m_press = nxt_press;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("model_mode", 32'(mode0), 32'(m_mode));
        chk("model_init", 32'(init0), 32'(m_init));
        chk("model_chg", 32'(chg0), 32'(e_chg));
        chk("model_led", 32'(led0), 32'(e_led));
        chk("model_ch", 32'(ch0), 32'(e_ch));
    endtask

    task automatic press(input int n);
        btn0 = 1'b0;
        repeat (n) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
        btn0 = 1'b1;
        repeat (4) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
        repeat (6) step();
    endtask

    initial begin
        int         n;
        int         cnt;
        logic [3:0] tp;

        vecs[0] = '{2, 1, 0, 4'b0101, 1, 1, 4'b0101};
        vecs[1] = '{3, 1, 0, 4'b1111, 2, 0, 4'b1000};
        vecs[2] = '{1, 0, 1, 4'b0000, 2, 1, 4'b1000};
        vecs[3] = '{3, 1, 1, 4'b1111, 3, 0, 4'b0001};
        vecs[4] = '{5, 1, 0, 4'b0000, 0, 1, 4'b1010};
        vecs[5] = '{4, 0, 0, 4'b0011, 1, 1, 4'b0011};
        vecs[6] = '{3, 0, 1, 4'b0000, 2, 1, 4'b1000};
        vecs[7] = '{3, 0, 0, 4'b0000, 3, 0, 4'b0001};
        vecs[8] = '{3, 0, 1, 4'b0110, 0, 0, 4'b1010};

        // reset state
        slow = 1'b1;
        repeat (3) step();
        chk("rst_mode", 32'(mode0), 0);
        chk("rst_init", 32'(init0), 1);
        chk("rst_chg", 32'(chg0), 0);
        chk("rst_ch", 32'(ch0), 0);
        chk("rst_led", 32'(led0), 0);

        rst_n = 1'b1;
        tick  = 1'b1;
        step();
        tick  = 1'b0;
        chk("idle_ch", 32'(ch0), 32'h0000_000a);
        chk("idle_led", 32'(led0), 1);
        chk("idle_init", 32'(init0), 1);
        slow = 1'b0;
        step();
        chk("idle_led_follow", 32'(led0), 0);

        // press debounced with a tick every cycle: exact change timeline
        timed = 4'b0110;
        btn0  = 1'b0;
        tick  = 1'b1;
        repeat (3) step();
        tick  = 1'b0;
        btn0  = 1'b1;
        n = 0;
        while (mode0 != 2'd1 && n < 10) begin
            step();
            n++;
        end
        chk("p3_mode", 32'(mode0), 1);
        chk("p3_init", 32'(init0), 0);
        chk("p3_ch_g0", 32'(ch0), 0);
        cnt = int'(chg0);
        step();
        chk("p3_ch_g1", 32'(ch0), 0);
        chk("p3_chg", 32'(chg0), 1);
        cnt += int'(chg0);
        for (int k = 0; k < 4; k++) begin
            timed = 4'($urandom);
            tp    = timed;
            step();
            chk("p3_timed", 32'(ch0), 32'(tp));
            cnt += int'(chg0);
        end
        chk("p3_chg_once", 32'(cnt), 1);
        repeat (4) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end

        // table of presses and per-mode outputs
        for (int i = 0; i < 9; i++) begin
            press(vecs[i].n);
            slow  = vecs[i].s;
            fast  = vecs[i].f;
            timed = vecs[i].t;
            step();
            step();
            chk("vec_mode", 32'(mode0), 32'(vecs[i].m));
            chk("vec_led", 32'(led0), 32'(vecs[i].l));
            chk("vec_ch", 32'(ch0), 32'(vecs[i].c));
        end

        // back-to-back presses restart the guard (DS=1, GUARD=4)
        timed = '0;
        btn1  = 1'b0; tick = 1'b1; step();
        btn1  = 1'b1; step();
        chk("g4_mode1", 32'(mode1), 1);
        btn1  = 1'b0; step();
        tick  = 1'b0; step();
        chk("g4_mode2", 32'(mode1), 2);
        chk("g4_ch_0", 32'(ch1), 0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("g4_ch_hold", 32'(ch1), 0);
        end
        step();
        chk("g4_ch_end", 32'(ch1), 32'h0000_0008);
        btn1 = 1'b1;
        tick = 1'b1; step(); step();
        tick = 1'b0;

`ifdef MODE_DIRECT_SELECT_EN
        // load coincident with an accepted press wins
        btn0 = 1'b0; tick = 1'b1;
        repeat (3) step();
        tick = 1'b0; ld0 = 1'b1; sel0 = 2'd3;
        step();
        ld0 = 1'b0; btn0 = 1'b1;
        step();
        chk("ld_vs_press", 32'(mode0), 3);
        repeat (4) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
        foreach (sel2[i]) sel2[i] = 1'b0;
        ld2 = 1'b1; sel2 = 3'd5; step();
        ld2 = 1'b0; step();
        chk("ld_inv5", 32'(mode2), 0);
        chk("ld_inv5_init", 32'(init2), 1);
        ld2 = 1'b1; sel2 = 3'd7; step();
        ld2 = 1'b0; step();
        chk("ld_inv7", 32'(mode2), 0);
        ld2 = 1'b1; sel2 = 3'd4; step();
        ld2 = 1'b0;
        chk("ld_4", 32'(mode2), 4);
        chk("ld_4_init", 32'(init2), 0);
        step();
        chk("ld_4_chg", 32'(chg2), 1);
        repeat (4) step();
        ld2 = 1'b1; step();
        ld2 = 1'b0;
        chk("ld_same", 32'(mode2), 4);
        step();
        chk("ld_same_chg", 32'(chg2), 1);
`endif

        // button held through reset is not a press
        btn0  = 1'b0;
        rst_n = 1'b0;
        tick  = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (8) step();
        tick = 1'b0;
        step();
        chk("held_rst_mode", 32'(mode0), 0);
        chk("held_rst_init", 32'(init0), 1);
        btn0 = 1'b1;
        repeat (4) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
        press(3);
        chk("held_rst_repress", 32'(mode0), 1);

        // randomized run against the model
        for (int k = 0; k < 4000; k++) begin
            tick  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) btn0 = ~btn0;
            slow  = 1'($urandom);
            fast  = 1'($urandom);
            timed = 4'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
`ifdef MODE_DIRECT_SELECT_EN
            ld0  = ($urandom_range(0, 39) == 0);
            sel0 = 2'($urandom);
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
